// File: rtl/frame_buffer_writer.sv
// Assembles RGB444 pixels from a sync-prefixed byte stream and writes them
// sequentially into port A of the frame-buffer BRAM, with inter-byte timeout.
module frame_buffer_writer #(
  parameter int          IMG_W       = 320,
  parameter int          IMG_H       = 240,
  parameter int          ADDR_W      = 17,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000,
  parameter int          TO_W        = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  // Handshake: a byte transfers on any rising edge where in_valid && in_ready.
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pix, pix_next;
  logic [3:0]        red, red_next;
  logic [TO_W-1:0]   cnt, cnt_next;
  logic [ADDR_W-1:0] addr_next;
  logic [11:0]       data_next;
  logic              err_next;
  logic              wr_en_next;
  logic              done_next;
  logic              busy_next;
  logic              accept;
  logic              expired;

  assign in_ready = (state == S_IDLE) || (state == S_HI) || (state == S_LO);
  assign accept   = in_valid && in_ready;
  // An accepted byte on the limit cycle wins over the timeout.
  assign expired  = !accept && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pix        <= '0;
      red        <= '0;
      cnt        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_next;
      pix        <= pix_next;
      red        <= red_next;
      cnt        <= cnt_next;
      wr_en      <= wr_en_next;
      wr_addr    <= addr_next;
      wr_data    <= data_next;
      busy       <= busy_next;
      frame_done <= done_next;
      error      <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    pix_next   = pix;
    red_next   = red;
    cnt_next   = cnt;
    addr_next  = wr_addr;
    data_next  = wr_data;
    err_next   = error;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (accept && (in_data == SYNC_BYTE)) begin
          state_next = S_HI;
          pix_next   = '0;
          err_next   = 1'b0;
        end
      end
      S_HI, S_LO: begin
        if (accept) begin
          cnt_next = '0;
          if (state == S_HI) begin
            red_next   = in_data[3:0];
            state_next = S_LO;
          end else begin
            addr_next  = pix;
            data_next  = {red, in_data};
            state_next = S_WR;
          end
        end else if (expired) begin
          cnt_next   = '0;
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_WR: begin
        cnt_next = '0;
        if (pix == LAST_PIX) begin
          state_next = S_DONE;
        end else begin
          pix_next   = pix + 1'b1;
          state_next = S_HI;
        end
      end
      S_DONE: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
    // Registered status follows the state being entered.
    wr_en_next = (state_next == S_WR);
    done_next  = (state_next == S_DONE);
    busy_next  = (state_next == S_HI) || (state_next == S_LO) || (state_next == S_WR);
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed plus randomized checks of frame_buffer_writer on a 4x2 image with a
// 16-cycle timeout; writes are checked against a byte-stream reference model.
module tb_frame_buffer_writer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = 17;
  localparam int TO_CYC = 16;
  localparam int TO_W   = 5;
  localparam int W      = ADDR_W + 12;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              busy;
  logic              frame_done;
  logic              error;

  int total = 0;
  int bad = 0;
  int exp_addr = 0;
  int done_cnt = 0;
  logic prev_last = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [7:0] s1_hi[NPIX];
  logic [7:0] s1_lo[NPIX];

  frame_buffer_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO_CYC), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $error("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the next expected {addr,data}.
  always @(negedge clk) begin
    if (wr_en) begin
      chk("wr_ready_low", {31'd0, in_ready}, 32'd0);
      chk("wr_busy", {31'd0, busy}, 32'd1);
      chk("wr_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        chk("wr_addr_data", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
      end
    end
    if (frame_done) begin
      done_cnt++;
      chk("done_after_last", {31'd0, prev_last}, 32'd1);
      chk("done_ready_low", {31'd0, in_ready}, 32'd0);
      chk("done_busy_low", {31'd0, busy}, 32'd0);
    end
    prev_last <= wr_en && (wr_addr == ADDR_W'(NPIX - 1));
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int n;
    if (gap > 0) idle(gap);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    chk("byte_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_sync(input int gap);
    send_byte(8'hA5, gap);
    exp_addr = 0;
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo, input int ghi, input int glo);
    send_byte(hi, ghi);
    send_byte(lo, glo);
    exp_q.push_back({ADDR_W'(exp_addr), hi[3:0], lo});
    exp_addr++;
  endtask

  task automatic random_frame();
    send_sync(0);
    for (int i = 0; i < NPIX; i++) send_pixel(8'($urandom), 8'($urandom), 0, 0);
    idle(4);
  endtask

  initial begin
    logic [7:0] nb;
    for (int i = 0; i < NPIX; i++) begin
      s1_hi[i] = 8'(8'h0F - i);
      s1_lo[i] = 8'(8'h12 + 8'h22 * i);
    end

    // Reset state
    #12;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    idle(2);

    // 1: back-to-back frame
    send_sync(0);
    chk("s1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < NPIX; i++) send_pixel(s1_hi[i], s1_lo[i], 0, 0);
    idle(4);
    chk("s1_done_cnt", 32'(done_cnt), 32'd1);
    chk("s1_idle_busy", {31'd0, busy}, 32'd0);

    // 2: noise before sync is discarded
    send_byte(8'h00, 0);
    send_byte(8'h55, 0);
    for (int i = 0; i < 3; i++) begin
      nb = 8'($urandom);
      if (nb == 8'hA5) nb = 8'h5A;
      send_byte(nb, $urandom_range(0, 3));
    end
    idle(3);
    chk("s2_noise_busy", {31'd0, busy}, 32'd0);
    random_frame();

    // 3: timeout after one HI byte, then recovery
    send_sync(0);
    send_byte(8'($urandom), 0);
    idle(TO_CYC - 1);
    chk("s3_pre_error", {31'd0, error}, 32'd0);
    chk("s3_pre_busy", {31'd0, busy}, 32'd1);
    idle(1);
    chk("s3_error", {31'd0, error}, 32'd1);
    chk("s3_busy", {31'd0, busy}, 32'd0);
    chk("s3_ready", {31'd0, in_ready}, 32'd1);
    idle(20);
    chk("s3_error_sticky", {31'd0, error}, 32'd1);
    chk("s3_done_cnt", 32'(done_cnt), 32'd2);
    send_sync(0);
    chk("s3_error_clear", {31'd0, error}, 32'd0);
    for (int i = 0; i < NPIX; i++) send_pixel(8'($urandom), 8'($urandom), 0, 0);
    idle(4);

    // 4: sync value as pixel data, and bytes arriving exactly on the limit
    send_sync(0);
    send_pixel(8'($urandom), 8'($urandom), 0, 0);
    send_pixel(8'($urandom), 8'($urandom), TO_CYC - 1, TO_CYC - 1);
    send_pixel(8'hA5, 8'hA5, 0, 0);
    for (int i = 3; i < NPIX; i++) send_pixel(8'($urandom), 8'($urandom), 0, 0);
    idle(4);
    chk("s4_no_error", {31'd0, error}, 32'd0);
    chk("s4_done_cnt", 32'(done_cnt), 32'd4);

    // 5: asynchronous reset between HI and LO of pixel 3
    send_sync(0);
    for (int i = 0; i < 3; i++) send_pixel(8'($urandom), 8'($urandom), 0, 0);
    send_byte(8'($urandom), 0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("s5_wr_en", {31'd0, wr_en}, 32'd0);
    chk("s5_wr_addr", 32'(wr_addr), 32'd0);
    chk("s5_wr_data", 32'(wr_data), 32'd0);
    chk("s5_busy", {31'd0, busy}, 32'd0);
    chk("s5_done", {31'd0, frame_done}, 32'd0);
    chk("s5_error", {31'd0, error}, 32'd0);
    idle(3);
    #2 reset = 1'b1;
    idle(2);
    random_frame();

    // 6: scenario 1 data with random gaps below the timeout
    send_sync($urandom_range(0, 12));
    for (int i = 0; i < NPIX; i++)
      send_pixel(s1_hi[i], s1_lo[i], $urandom_range(0, 12), $urandom_range(0, 12));
    idle(4);

    chk("final_done_cnt", 32'(done_cnt), 32'd6);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
